// File: rtl/lm80c_pkg.sv
// Shared LM80C definitions: SDRAM address type, memory map constants and the
// state encoding of the PRG end-pointer fixup sequencer.
package lm80c_pkg;

    typedef logic [24:0] sdram_addr_t;

    localparam sdram_addr_t LM80C_RAM_BASE   = 25'h10000;
    localparam logic [15:0] LM80C_PTR_PROGND = 16'h55e4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_WLO     = 3'd2,
        ST_WHI     = 3'd3,
        ST_DONE    = 3'd4
    } fixup_state_t;

endpackage

// File: rtl/lm80c_prg_ptr_fixup.sv
// After a PRG download finishes, writes the BASIC end-of-program pointer
// (last written address + 1, little-endian) into SDRAM so BASIC sees the
// loaded program. Outputs are decoded from registered state only.
module lm80c_prg_ptr_fixup
    import lm80c_pkg::*;
#(
    parameter sdram_addr_t PTR_ADDR = LM80C_RAM_BASE + sdram_addr_t'(LM80C_PTR_PROGND),
    parameter int unsigned WR_HOLD  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ena,
    input  logic        dl_active,
    input  logic        dl_is_prg,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    output logic        mem_wr,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] prg_end
);

    localparam int HOLD_W = $clog2(WR_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_HOLD - 1);

    fixup_state_t      r_state;
    fixup_state_t      w_state_next;
    logic              r_dl_active_d;
    logic              r_armed;
    logic              r_any_wr;
    logic [15:0]       r_end;
    logic [HOLD_W-1:0] r_hold;
    logic [15:0]       r_prg_end;

    logic w_rise;
    logic w_fall;
    logic w_hold_done;
    logic w_unused_addr_hi;

    // Only the low 16 bits of the download address form the BASIC pointer.
    assign w_unused_addr_hi = ^dl_addr[24:16];

    // r_armed blocks a spurious rise when dl_active is already high as reset lifts.
    assign w_rise      = dl_active & ~r_dl_active_d & r_armed;
    assign w_fall      = ~dl_active & r_dl_active_d;
    assign w_hold_done = ena && (r_hold == HOLD_LAST);

    // Next-state decode: download tracking, timed pointer writes, abort on new download.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise && dl_is_prg)
                    w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_fall)
                    w_state_next = (r_any_wr || dl_wr) ? ST_WLO : ST_IDLE;
            end
            ST_WLO: begin
                if (w_rise)
                    w_state_next = dl_is_prg ? ST_CAPTURE : ST_IDLE;
                else if (w_hold_done)
                    w_state_next = ST_WHI;
            end
            ST_WHI: begin
                if (w_rise)
                    w_state_next = dl_is_prg ? ST_CAPTURE : ST_IDLE;
                else if (w_hold_done)
                    w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, edge history, captured end address, hold counter and result register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_dl_active_d <= 1'b0;
            r_armed       <= 1'b0;
            r_any_wr      <= 1'b0;
            r_end         <= '0;
            r_hold        <= '0;
            r_prg_end     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_dl_active_d <= dl_active;
            r_armed       <= r_armed | ~dl_active;

            if (w_state_next == ST_CAPTURE && r_state != ST_CAPTURE) begin
                r_any_wr <= 1'b0;
                r_end    <= '0;
            end else if (r_state == ST_CAPTURE && dl_wr) begin
                r_any_wr <= 1'b1;
                r_end    <= dl_addr[15:0] + 16'd1;
            end

            if (w_state_next != r_state)
                r_hold <= '0;
            else if ((r_state == ST_WLO || r_state == ST_WHI) && ena)
                r_hold <= r_hold + HOLD_W'(1);

            if (r_state == ST_DONE)
                r_prg_end <= r_end;
        end
    end

    // Memory port and status outputs decoded from the registered state.
    always_comb begin
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        case (r_state)
            ST_WLO: begin
                mem_wr   = 1'b1;
                mem_addr = PTR_ADDR;
                mem_data = r_end[7:0];
            end
            ST_WHI: begin
                mem_wr   = 1'b1;
                mem_addr = PTR_ADDR + 25'd1;
                mem_data = r_end[15:8];
            end
            default: ;
        endcase
        busy    = (r_state == ST_WLO) || (r_state == ST_WHI);
        done    = (r_state == ST_DONE);
        prg_end = r_prg_end;
    end

endmodule

// File: doc/lm80c_prg_ptr_fixup.md
LM80C_PRG_PTR_FIXUP -- requirements
Module: lm80c_prg_ptr_fixup

Interface
REQ-001 Parameter PTR_ADDR, default 25'h155e4: SDRAM byte address of the BASIC end-of-program pointer (low byte; high byte at PTR_ADDR+1).
REQ-002 Parameter WR_HOLD, default 2: number of ena strobes each fixup write is held on the memory port.
REQ-003 Port clk, in, 1: single clock, the system clock; all logic on its rising edge.
REQ-004 Port reset_n, in, 1: reset, synchronous, active-low.
REQ-005 Port ena, in, 1: step enable (CPU-rate strobe); the write timing counts only cycles with ena=1.
REQ-006 Port dl_active, in, 1: a downloader transfer is in progress.
REQ-007 Port dl_is_prg, in, 1: the current transfer is a PRG file; sampled on the dl_active rising edge.
REQ-008 Port dl_wr, in, 1: the downloader writes a byte this cycle.
REQ-009 Port dl_addr, in, 25: byte address of the downloader write.
REQ-010 Port mem_wr, out, 1: fixup write request to the SDRAM mux.
REQ-011 Port mem_addr, out, 25: fixup write address.
REQ-012 Port mem_data, out, 8: fixup write data.
REQ-013 Port busy, out, 1: high while the block owns the memory port (states WLO, WHI).
REQ-014 Port done, out, 1: one-cycle pulse when the pointer is fully written.
REQ-015 Port prg_end, out, 16: last computed end-of-program value.

Function
REQ-016 The FSM SHALL have the states IDLE, CAPTURE, WLO, WHI and DONE.
REQ-017 IDLE->CAPTURE on a dl_active 0->1 edge with dl_is_prg=1; edges with dl_is_prg=0 leave the FSM in IDLE.
REQ-018 On entry to CAPTURE, the any_wr flag and the end register SHALL clear.
REQ-019 In CAPTURE, each dl_wr=1 cycle SHALL set any_wr and load end <= dl_addr[15:0]+1, computed mod 2^16 (so 0xFFFF wraps to 0x0000).
REQ-020 end tracks the last written address, not the maximum.
REQ-021 On a dl_active 1->0 edge in CAPTURE: go to WLO if any_wr=1, else to IDLE with no write.
REQ-022 A dl_wr coinciding with the falling-edge cycle SHALL still be captured.
REQ-023 WLO SHALL drive mem_addr=PTR_ADDR and mem_data=end[7:0], with mem_wr=1 held for exactly WR_HOLD ena strobes, then move to WHI.
REQ-024 WHI SHALL behave the same with mem_addr=PTR_ADDR+1 and mem_data=end[15:8], then move to DONE.
REQ-025 DONE SHALL assert done for one clk cycle, load prg_end<=end and return to IDLE.
REQ-026 Cycles with ena=0 SHALL neither advance the hold counter nor change mem_addr or mem_data.
REQ-027 mem_wr=0 in IDLE, CAPTURE and DONE; mem_addr and mem_data are 0 whenever mem_wr=0.
REQ-028 A dl_active 0->1 edge in WLO or WHI SHALL abort the fixup: mem_wr drops on the next cycle, no done pulse, prg_end is unchanged, and the FSM enters CAPTURE (dl_is_prg=1) or IDLE (dl_is_prg=0).
REQ-029 dl_wr outside CAPTURE SHALL be ignored.
REQ-030 The edge detector SHALL use a registered copy of dl_active; no combinational path from any input to any output.

Reset
REQ-031 reset_n=0 at a clock edge SHALL force state=IDLE, mem_wr=0, mem_addr=0, mem_data=0, busy=0, done=0, prg_end=0, end=0, any_wr=0, hold counter=0 and the dl_active history=0.
REQ-032 Reset mid-write SHALL drop mem_wr on the next cycle and never emit done.
REQ-033 If dl_active=1 while reset is released, no CAPTURE entry occurs until a fresh 0->1 edge.

Structure
REQ-034 A shared package lm80c_pkg SHALL hold the FSM state enum, the 25-bit SDRAM address typedef and the constants LM80C_RAM_BASE=25'h10000 and LM80C_PTR_PROGND=16'h55e4.
REQ-035 The PTR_ADDR default is LM80C_RAM_BASE+LM80C_PTR_PROGND.
REQ-036 The block is a single module with no sub-modules.
REQ-037 The hold counter is ceil(log2(WR_HOLD+1)) bits wide.

Verification
REQ-038 PRG load: ena every cycle, 16 writes at 0x15608..0x15617, dl_active falls -> writes 0x18@0x155e4 then 0x56@0x155e5, each held 2 strobes; done pulses once; prg_end=0x5618.
REQ-039 Wrap: the last write is at 0x1FFFF -> prg_end=0x0000; data bytes written are 0x00 and 0x00.
REQ-040 Non-PRG and empty cases: dl_is_prg=0 with 100 writes, and dl_is_prg=1 with 0 writes -> mem_wr never asserts, done never pulses, prg_end unchanged.
REQ-041 Sparse ena (1 in 8 cycles): each write phase holds mem_wr for exactly 16 clk cycles; mem_addr and mem_data are stable throughout.
REQ-042 Abort: a new dl_active rise during WHI -> mem_wr=0 the next cycle, no done, state CAPTURE; the second PRG then completes normally.
REQ-043 Reset asserted 1 cycle into WLO -> all outputs 0 the next cycle; no write or done until the next PRG download.
